// File: rtl/uart_rx_pid_parser.sv
// UART byte-stream frame parser: AA, PID, four payload bytes, 55.
// Frames with a bad PID, bad trailer or an inter-byte timeout are discarded.
module uart_rx_pid_parser #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] frame_data,
  output logic        frame_test,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_HUNT,
    S_PID,
    S_DATA,
    S_END
  } state_t;

  localparam logic [7:0] SOF   = 8'hAA;
  localparam logic [7:0] EOF   = 8'h55;
  localparam logic [7:0] PID_T = 8'h42;
  localparam logic [7:0] PID_N = 8'h69;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] work;
  logic [1:0]  idx;
  logic        pid_test;
  logic [15:0] gap;
  logic        timeout;
  logic        valid_nxt;
  logic        err_nxt;
  logic        latch_pid;
  logic        store;
  logic        commit;

  assign busy = (state != S_HUNT);

  // The gap reaches the limit on this edge unless a byte arrives now.
  assign timeout = busy && !rx_valid &&
                   (gap >= TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    latch_pid = 1'b0;
    store     = 1'b0;
    commit    = 1'b0;
    if (timeout) begin
      err_nxt   = 1'b1;
      state_nxt = S_HUNT;
    end else if (rx_valid) begin
      unique case (state)
        S_HUNT: begin
          if (rx_data == SOF) state_nxt = S_PID;
        end
        S_PID: begin
          if (rx_data == PID_T || rx_data == PID_N) begin
            latch_pid = 1'b1;
            state_nxt = S_DATA;
          end else if (rx_data != SOF) begin
            err_nxt   = 1'b1;
            state_nxt = S_HUNT;
          end
        end
        S_DATA: begin
          store = 1'b1;
          if (idx == 2'd3) state_nxt = S_END;
        end
        S_END: begin
          if (rx_data == EOF) begin
            commit    = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = S_HUNT;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = (rx_data == SOF) ? S_PID : S_HUNT;
          end
        end
        default: state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      frame_data  <= '0;
      frame_test  <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      gap         <= '0;
      work        <= '0;
      idx         <= '0;
      pid_test    <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
      if (err_nxt && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (latch_pid) begin
        pid_test <= (rx_data == PID_T);
        idx      <= '0;
      end
      if (store) begin
        work[{idx, 3'b000} +: 8] <= rx_data;
        idx <= idx + 2'd1;
      end
      if (commit) begin
        frame_data <= work;
        frame_test <= pid_test;
      end
      if (!busy || rx_valid)
        gap <= '0;
      else if (gap != 16'hFFFF)
        gap <= gap + 16'd1;
    end
  end

endmodule

// File: doc/uart_rx_pid_parser.md
UART_RX_PID_PARSER -- requirements
Module: uart_rx_pid_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning the max clk cycles allowed between bytes inside a frame.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  byte from UART receive core.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 SHALL have port frame_data  output  32  last good payload, registered.
REQ-007 SHALL have port frame_test  output  1  1 = last good frame carried PID 0x42, 0 = PID 0x69.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse, new good frame on frame_data/frame_test.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, frame discarded.
REQ-010 SHALL have port err_count  output  8  saturating count of frame_err pulses.
REQ-011 SHALL have port busy  output  1  high whenever state is not S_HUNT.

Function
REQ-012 SHALL parse frames of 7 bytes: 0xAA, PID, D0, D1, D2, D3, 0x55; frame_data = {D3,D2,D1,D0} (first payload byte is LSB).
REQ-013 SHALL implement states S_HUNT, S_PID, S_DATA, S_END; only bytes with rx_valid=1 advance the FSM.
REQ-014 S_HUNT: byte 0xAA -> S_PID; any other byte ignored silently (no frame_err).
REQ-015 S_PID: 0x42 or 0x69 -> latch PID, clear 2-bit data index, -> S_DATA; 0xAA -> stay S_PID (resync, no error); any other byte -> frame_err, -> S_HUNT.
REQ-016 S_DATA: every byte (including 0xAA/0x55) stored into working buffer at index position; after 4th byte -> S_END.
REQ-017 S_END: 0x55 -> copy working buffer to frame_data, PID flag to frame_test, pulse frame_valid, -> S_HUNT; 0xAA -> frame_err, -> S_PID; other -> frame_err, -> S_HUNT.
REQ-018 frame_valid SHALL assert in the cycle after the clk edge on which the 0x55 byte is sampled (1-cycle latency), for exactly one cycle.
REQ-019 frame_data and frame_test SHALL change only together with a frame_valid pulse and hold otherwise, including across errors.
REQ-020 Working buffer SHALL be separate from frame_data; partial frames never appear on frame_data.
REQ-021 Gap counter (16 bits) SHALL clear on every rx_valid and in S_HUNT, and increment each cycle otherwise, saturating.
REQ-022 When not in S_HUNT and gap counter reaches TIMEOUT_CYCLES with rx_valid=0, SHALL pulse frame_err and return to S_HUNT.
REQ-023 If rx_valid=1 in the same cycle the timeout is reached, the byte SHALL be processed normally and no timeout error raised.
REQ-024 err_count SHALL increment by 1 per frame_err pulse and saturate at 8'hFF.
REQ-025 frame_valid and frame_err SHALL never assert in the same cycle.
REQ-026 Back-to-back frames (0xAA the cycle after 0x55) SHALL both be accepted.

Reset
REQ-027 On rst=1 at a clk edge: state=S_HUNT, frame_data=0, frame_test=0, frame_valid=0, frame_err=0, err_count=0, busy=0, gap counter=0, working buffer=0.
REQ-028 Reset mid-frame SHALL discard the partial frame without a frame_err pulse; bytes with rx_valid during rst are ignored.

Verification
REQ-029 Bytes AA 69 78 56 34 12 55 -> one frame_valid, frame_data=32'h12345678, frame_test=0, err_count=0.
REQ-030 Bytes AA 42 AA 55 AA 55 55 -> frame_valid, frame_data=32'h55AA55AA, frame_test=1 (delimiters accepted as payload).
REQ-031 Bytes AA 13 -> frame_err pulse, err_count=1, frame_data unchanged; then AA 69 01 00 00 00 55 -> frame_data=32'h00000001.
REQ-032 TIMEOUT_CYCLES=10: AA 69 01 then 10 idle cycles -> frame_err, busy=0; byte arriving exactly on the 10th cycle -> no error, frame continues.
REQ-033 Bytes AA 69 01 02 03 04 AA then 69 05 06 07 08 55 -> one frame_err then frame_valid with frame_data=32'h08070605.
REQ-034 Assert rst after AA 69 01 02 -> no frame_err, all outputs at reset values; following full good frame accepted normally.
